// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM download path: FIFO entry layout and request FSM states.
package rom_loader_pkg;

    localparam int WORD_BYTES = 4;

    // Only wa[21:0] survives the {wa,1'b0} shift into a 23-bit SDRAM address.
    typedef struct packed {
        logic [21:0] addr;
        logic [31:0] data;
    } fifo_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// SDRAM write-port bundle between the ROM loader (master) and the controller's write arbiter (slave).
interface rom_loader_if;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_we;
    logic        sdram_req;
    logic        sdram_ack;

    modport master (
        output sdram_addr,
        output sdram_data,
        output sdram_we,
        output sdram_req,
        input  sdram_ack
    );

    modport slave (
        input  sdram_addr,
        input  sdram_data,
        input  sdram_we,
        input  sdram_req,
        output sdram_ack
    );
endinterface

// File: rtl/rom_loader_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    // Asynchronous read of the head entry gives fall-through without an extra stage.
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/rom_loader.sv
// Packs the hps_io ioctl byte stream into 32-bit words, buffers them and writes them
// to SDRAM through a req/ack port.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [22:0] ADDR_OFFSET = 23'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    rom_loader_if.master sdram,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    // Byte assembler state
    logic [31:0] word_reg,  word_next;
    logic [3:0]  mask_reg,  mask_next;
    logic [22:0] wa_reg,    wa_next;
    logic        dl_d_reg;

    logic [22:0] in_wa;
    logic [1:0]  in_lane;
    logic        accept;
    logic        jump;
    logic        dl_fall;
    logic [3:0]  base_mask;
    logic [31:0] base_word;
    logic [3:0]  merged_mask;
    logic [31:0] merged_word;

    logic        push;
    fifo_entry_t push_entry;
    logic        pop;
    fifo_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;

    state_t      state_reg, state_next;
    logic [22:0] addr_reg,  addr_next;
    logic [31:0] data_reg,  data_next;
    logic        overflow_reg;
    logic        busy_prev_reg;

    assign in_wa   = ioctl_addr[24:2];
    assign in_lane = ioctl_addr[1:0];
    assign accept  = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
    assign jump    = accept & (mask_reg != 4'd0) & (in_wa != wa_reg);
    assign dl_fall = dl_d_reg & ~ioctl_download;

    // On an address jump the held word leaves this cycle, so the new byte merges into zeros.
    assign base_mask   = jump ? 4'd0  : mask_reg;
    assign base_word   = jump ? 32'd0 : word_reg;
    assign merged_mask = base_mask | (4'b0001 << in_lane);

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = (in_lane == 2'(gi)) ? ioctl_data
                                                                : base_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        push       = 1'b0;
        push_entry = '{addr: wa_reg[21:0], data: word_reg};
        mask_next  = mask_reg;
        word_next  = word_reg;
        wa_next    = wa_reg;
        if (accept) begin
            wa_next = in_wa;
            if (jump) begin
                push = 1'b1;
            end
            // A fresh byte after a jump sets a single lane, so both pushes never coincide.
            if (merged_mask == 4'hF) begin
                push       = 1'b1;
                push_entry = '{addr: in_wa[21:0], data: merged_word};
                mask_next  = 4'd0;
                word_next  = 32'd0;
            end else begin
                mask_next = merged_mask;
                word_next = merged_word;
            end
        end else if (dl_fall && (mask_reg != 4'd0)) begin
            push      = 1'b1;
            mask_next = 4'd0;
            word_next = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg <= '0;
            mask_reg <= '0;
            wa_reg   <= '0;
            dl_d_reg <= 1'b0;
        end else begin
            word_reg <= word_next;
            mask_reg <= mask_next;
            wa_reg   <= wa_next;
            dl_d_reg <= ioctl_download;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    addr_next  = {head.addr, 1'b0} + ADDR_OFFSET;
                    data_next  = head.data;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (sdram.sdram_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            data_reg      <= '0;
            overflow_reg  <= 1'b0;
            busy_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            busy_prev_reg <= busy;
            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign sdram.sdram_addr = addr_reg;
    assign sdram.sdram_data = data_reg;
    assign sdram.sdram_req  = (state_reg == REQ);
    assign sdram.sdram_we   = (state_reg == REQ);

    assign busy     = ioctl_download | (mask_reg != 4'd0) | ~fifo_empty | (state_reg == REQ);
    assign done     = busy_prev_reg & ~busy;
    assign overflow = overflow_reg;
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Receiving end of the HPS ioctl download stream.
- Packs incoming ROM bytes into 32-bit words and buffers them in a small FIFO.
- Issues SDRAM write requests on the controller's req/ack port.
- Sits between hps_io and the SDRAM controller's write arbiter. Game logic is held in reset while it runs.

Parameters:
- ROM_INDEX, 0, ioctl_index value accepted as ROM data; other indices are ignored.
- FIFO_DEPTH, 8, word FIFO entries; power of two, >= 2.
- ADDR_OFFSET, 0, 23-bit value added to every generated sdram_addr; modulo 2^23.

Ports:
- clk  in  1  system clock (48 MHz)
- reset  in  1  synchronous, active-high
- ioctl_addr  in  25  byte address of current download byte
- ioctl_data  in  8  download byte
- ioctl_wr  in  1  one-cycle strobe, byte valid
- ioctl_download  in  1  high for the whole download
- ioctl_index  in  8  download slot index
- sdram_addr  out  23  16-bit-word address, always even
- sdram_data  out  32  write word, little-endian
- sdram_we  out  1  high whenever sdram_req is high
- sdram_req  out  1  write request
- sdram_ack  in  1  one-cycle pulse, request accepted
- busy  out  1  download active, or data still pending
- done  out  1  one-cycle pulse when last word accepted
- overflow  out  1  sticky, FIFO overrun occurred

Behaviour:
- Reset values: all outputs 0. Assembler, FIFO, FSM and overflow are cleared. Reset mid-operation discards all pending data; no request is left asserted.
- Accept: a byte is accepted only on ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX).
- Assembler holds a 32-bit word, a 4-bit byte-valid mask and word address wa = ioctl_addr[24:2].
  - Accepted byte is written to lane ioctl_addr[1:0] (lane 0 = bits 7:0) and its mask bit is set.
  - Same-cycle push: when the mask becomes 4'b1111, the word is pushed the same cycle, and the mask clears.
  - Non-sequential flush: an accepted byte whose wa differs from the held wa while the mask is nonzero first pushes the held partial word. Missing lanes are zero. The new byte then starts a fresh word in the same cycle.
  - End-of-download flush: on the falling edge of ioctl_download with a nonzero mask, the partial word is pushed, zero-padded.
- FIFO: entry = {wa, data}.
  - Push on a full FIFO drops the word and sets overflow.
  - Simultaneous push and pop when full is legal and not an overflow.
  - Read is first-word fall-through.
- Request FSM:
  - IDLE: if FIFO not empty, load sdram_addr = ({wa,1'b0} + ADDR_OFFSET) mod 2^23 and sdram_data; pop; go to REQ. Outputs are registered, so sdram_req rises one cycle after the FIFO becomes non-empty.
  - REQ: sdram_req = sdram_we = 1; addr and data are held stable. On sdram_ack, drop req the next cycle and return to IDLE.
  - Minimum spacing is 1 idle cycle between requests. ack outside REQ is ignored.
- busy = ioctl_download | mask != 0 | FIFO not empty | state == REQ.
- done: pulses for exactly one cycle on the cycle busy falls, i.e. the cycle after the final ack. A download with no accepted bytes produces a done pulse one cycle after ioctl_download falls.
- Address wrap: wa + offset wraps silently at 2^23.

Decomposition:
- Package rom_loader_pkg:
  - typedef fifo_entry_t (packed: addr 22 bits, data 32 bits).
  - enum state_t {IDLE, REQ}.
  - localparam WORD_BYTES = 4.
- Sub-module sync_fifo: parameterised width and depth; push, pop, full, empty, FWFT output. Reusable elsewhere.

Test Plan:
- Reset: assert reset for 3 cycles -> all outputs 0, busy 0.
- Sequential load: 8 bytes 0x00..0x07 at addr 0..7, ack 2 cycles after each req -> two writes, (addr 0, data 0x03020100) then (addr 2, data 0x07060504); done pulses once.
- Partial tail: 5 bytes 0xAA at addr 0..4, then drop ioctl_download -> second write is addr 2, data 0x000000AA; busy falls after its ack.
- Non-sequential jump: bytes at addr 0,1 then addr 0x100 -> write (addr 0, 0x0000BBAA) precedes any write to addr 0x80.
- Overflow: FIFO_DEPTH=2, ack held low, 16 sequential bytes -> overflow goes 1 and stays 1 until reset; the first two words are written correctly once acked.
- Filtering and offset: ioctl_index = ROM_INDEX+1 bytes -> no req. ADDR_OFFSET = 0x7FFFFE, byte at addr 4 -> sdram_addr = 0x000000 (wrap).
